ticket_dispenser: RTL and testbench
===================================

# ticket_dispenser

Customer-arrival transmitter for the bank-queue system. It accepts walk-in requests (a button pulse plus a requested service time) and assigns each one a sequential ticket number. Requests wait in a small buffer and are issued as one-cycle `in_valid`/`in_num`/`in_time` transactions into the counter/FIFO scheduler (`top`), with a guaranteed minimum spacing between issues. Invalid requests and requests that arrive while the buffer is full are refused and counted.

## Interface
Parameters:
- `DT_SZ`, 4: width of ticket number and service time.
- `BUF_D`, 2: depth of the pending-request buffer.
- `BUF_W`, 2: occupancy counter width, ceil(log2(BUF_D+1)).
- `GAP`, 2: minimum idle cycles between consecutive `out_valid` pulses (0 allowed).

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-high.
- `req` input 1: request strobe, sampled at each rising edge.
- `req_time` input DT_SZ: requested service time, valid with `req`.
- `req_ack` output 1: registered one-cycle pulse; the request was accepted.
- `req_nak` output 1: registered one-cycle pulse; the request was refused.
- `out_valid` output 1: issue strobe, connects to `top.in_valid`.
- `out_num` output DT_SZ: ticket number, connects to `top.in_num`.
- `out_time` output DT_SZ: service time, connects to `top.in_time`.
- `next_num` output DT_SZ: ticket number the next accepted request will receive.
- `pend_cnt` output BUF_W: buffer occupancy.
- `drop_cnt` output 8: refused-request count, saturates at 255.

## Operation
- **Accept rule.** At an edge with `req`=1, the request is accepted iff `req_time`≠0 and (`pend_cnt`<BUF_D or a pop happens at the same edge).
  - On accept: push {`next_num`, `req_time`}, increment `next_num`, pulse `req_ack`.
  - On refuse: pulse `req_nak`, increment `drop_cnt` (saturating), leave `next_num` unchanged.
- **Ticket numbering.** Numbers run 1..2^DT_SZ−1 and then wrap to 1. 0 is never issued because 0 means idle on `num_bus`.
- **Buffer.** BUF_D entries, strict FIFO order. The ticket number is bound at acceptance, not at issue.
- **Issue FSM states:**
  - IDLE: if the buffer is non-empty at an edge, pop the head, register `out_valid`=1 with its num/time, load the gap counter with GAP, and go to HOLD. If GAP=0, stay in IDLE.
  - HOLD: decrement the gap counter each edge. When it reaches 0 at an edge, go to IDLE; an issue is possible at the next edge.
- `out_valid` is high for exactly one cycle. `out_num`/`out_time` are 0 whenever `out_valid`=0.
- **Push and pop at the same edge** (including when the buffer is full) are both performed; `pend_cnt` is unchanged.
- **Push into an empty buffer** is not bypassed: the entry is issued at the following edge at the earliest.
- **Reset (any time, including mid-burst):** buffer is cleared, FSM goes to IDLE, all outputs are 0 except `next_num`=1. Pending requests are lost and are not counted as drops.

## Timing
- Request accepted at edge k with buffer empty and FSM idle → `out_valid` rises at edge k+1 and falls at edge k+2.
- `req_ack`/`req_nak` rise at the sampling edge k and are high for one cycle.
- Back-to-back issues: `out_valid` rising edges are exactly GAP+1 cycles apart while the buffer stays non-empty.
- Sustained throughput is one issue per GAP+1 cycles. Request bursts faster than that overflow once BUF_D entries are pending.
- `pend_cnt`, `next_num` and `drop_cnt` update at the same edge as the event that changes them.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DT_SZ=4, BUF_D=2, GAP=2.
1. **Reset:** hold `rst_n`=1 → all outputs 0, `next_num`=1. Release, then idle 10 cycles → `out_valid` never rises.
2. **Single request:** `req` with time 8 at edge 0 → `req_ack` at edge 0; `out_valid` at edge 1 with num 1, time 8; `pend_cnt` goes 1 → 0.
3. **Burst:** requests on consecutive edges 0..3 with times 1, 5, 2, 3.
   - Expect issues at edges 1 (num 1/time 1), 4 (2/5) and 7 (3/2).
   - The time-3 request at edge 3 is refused (buffer full, no pop): `req_nak`, `drop_cnt`=1.
4. **Zero time:** `req` with time 0 → `req_nak`, `drop_cnt`+1, `next_num` unchanged, nothing issued.
5. **Wrap-around:** 16 accepted requests, spaced ≥3 cycles apart → issued numbers 1..15, then 1. `drop_cnt` saturation: 260 refusals → 255.
6. **Reset mid-operation:** with 2 pending entries and FSM in HOLD, pulse reset → `out_valid` and `pend_cnt` are 0 immediately, `next_num`=1. The next request is issued as num 1.

Source files
------------

// File: rtl/ticket_dispenser.sv
// Walk-in request front end: numbers requests, buffers them, and issues them
// to the queue scheduler with a minimum idle gap between issues.
module ticket_dispenser #(
  parameter int DT_SZ = 4,
  parameter int BUF_D = 2,
  parameter int BUF_W = 2,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [DT_SZ-1:0] req_time,
  output logic             req_ack,
  output logic             req_nak,
  output logic             out_valid,
  output logic [DT_SZ-1:0] out_num,
  output logic [DT_SZ-1:0] out_time,
  output logic [DT_SZ-1:0] next_num,
  output logic [BUF_W-1:0] pend_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int               GAP_W    = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [BUF_W-1:0] BUF_FULL = BUF_W'(BUF_D);
  localparam logic [DT_SZ-1:0] NUM_MAX  = '1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BUF_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic [DT_SZ-1:0]   next_num_q, next_num_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               req_ack_q, req_ack_d;
  logic               req_nak_q, req_nak_d;
  logic               out_valid_q, out_valid_d;
  logic [DT_SZ-1:0]   out_num_q, out_num_d;
  logic [DT_SZ-1:0]   out_time_q, out_time_d;
  logic [DT_SZ-1:0]   ent_num_q  [BUF_D];
  logic [DT_SZ-1:0]   ent_num_d  [BUF_D];
  logic [DT_SZ-1:0]   ent_time_q [BUF_D];
  logic [DT_SZ-1:0]   ent_time_d [BUF_D];
  logic               pop;
  logic               push;
  logic [BUF_W-1:0]   wr_idx;

  // Pop decision uses registered occupancy, so a fresh push is never bypassed.
  always_comb begin
    pop    = (state_q == IDLE) && (pend_cnt_q != '0);
    push   = req && (req_time != '0) && ((pend_cnt_q < BUF_FULL) || pop);
    wr_idx = pop ? (pend_cnt_q - 1'b1) : pend_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pop && (GAP > 0)) begin
          state_d = HOLD;
          gap_d   = GAP_W'(GAP);
        end
      end
      HOLD: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-down FIFO: head always at entry 0, new entry lands after the survivors.
  always_comb begin
    ent_num_d  = ent_num_q;
    ent_time_d = ent_time_q;
    if (pop) begin
      for (int i = 0; i < BUF_D - 1; i++) begin
        ent_num_d[i]  = ent_num_q[i+1];
        ent_time_d[i] = ent_time_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < BUF_D; i++) begin
        if (BUF_W'(i) == wr_idx) begin
          ent_num_d[i]  = next_num_q;
          ent_time_d[i] = req_time;
        end
      end
    end
  end

  always_comb begin
    pend_cnt_d  = pend_cnt_q;
    next_num_d  = next_num_q;
    drop_cnt_d  = drop_cnt_q;
    req_ack_d   = push;
    req_nak_d   = req && !push;
    out_valid_d = pop;
    out_num_d   = pop ? ent_num_q[0]  : '0;
    out_time_d  = pop ? ent_time_q[0] : '0;
    if (push && !pop) begin
      pend_cnt_d = pend_cnt_q + 1'b1;
    end else if (pop && !push) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end
    // Zero marks an idle bus downstream, so numbering skips it on wrap.
    if (push) begin
      next_num_d = (next_num_q == NUM_MAX) ? DT_SZ'(1) : next_num_q + 1'b1;
    end
    if (req && !push && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      pend_cnt_q  <= '0;
      next_num_q  <= DT_SZ'(1);
      drop_cnt_q  <= '0;
      req_ack_q   <= 1'b0;
      req_nak_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_time_q  <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      pend_cnt_q  <= pend_cnt_d;
      next_num_q  <= next_num_d;
      drop_cnt_q  <= drop_cnt_d;
      req_ack_q   <= req_ack_d;
      req_nak_q   <= req_nak_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_time_q  <= out_time_d;
    end
  end

  for (genvar gi = 0; gi < BUF_D; gi++) begin : g_ent
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        ent_num_q[gi]  <= '0;
        ent_time_q[gi] <= '0;
      end else begin
        ent_num_q[gi]  <= ent_num_d[gi];
        ent_time_q[gi] <= ent_time_d[gi];
      end
    end
  end

  assign req_ack   = req_ack_q;
  assign req_nak   = req_nak_q;
  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_time  = out_time_q;
  assign next_num  = next_num_q;
  assign pend_cnt  = pend_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ticket_dispenser.sv
// Bench for ticket_dispenser: directed scenarios plus random traffic, each edge
// compared against a queue-and-timestamp reference model.
module tb_ticket_dispenser;

  localparam int DT_SZ = 4;
  localparam int BUF_D = 2;
  localparam int BUF_W = 2;
  localparam int GAP   = 2;
  localparam int NUM_MAX = (1 << DT_SZ) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req = 1'b0;
  logic [DT_SZ-1:0] req_time = '0;
  logic             req_ack, req_nak, out_valid;
  logic [DT_SZ-1:0] out_num, out_time, next_num;
  logic [BUF_W-1:0] pend_cnt;
  logic [7:0]       drop_cnt;

  ticket_dispenser #(.DT_SZ(DT_SZ), .BUF_D(BUF_D), .BUF_W(BUF_W), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_time(req_time),
    .req_ack(req_ack), .req_nak(req_nak), .out_valid(out_valid),
    .out_num(out_num), .out_time(out_time), .next_num(next_num),
    .pend_cnt(pend_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests as a queue, issue spacing as an edge timestamp.
  logic [2*DT_SZ-1:0] mq[$];
  int m_edge = 0;
  int m_next_allowed = 0;
  int m_next = 1;
  int m_drop = 0;
  int e_ack = 0, e_nak = 0, e_ov = 0, e_num = 0, e_time = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_next_allowed = m_edge;
    m_next = 1;
    m_drop = 0;
    e_ack = 0; e_nak = 0; e_ov = 0; e_num = 0; e_time = 0;
  endtask

  task automatic model_edge(input logic r, input logic [DT_SZ-1:0] t);
    logic [2*DT_SZ-1:0] e;
    bit do_pop;
    bit acc;
    do_pop = (mq.size() > 0) && (m_edge >= m_next_allowed);
    acc = r && (t != 0) && ((mq.size() < BUF_D) || do_pop);
    e_ov = 0; e_num = 0; e_time = 0;
    if (do_pop) begin
      e = mq.pop_front();
      e_ov = 1;
      e_num = int'(e[2*DT_SZ-1:DT_SZ]);
      e_time = int'(e[DT_SZ-1:0]);
      m_next_allowed = m_edge + GAP + 1;
    end
    e_ack = acc ? 1 : 0;
    e_nak = (r && !acc) ? 1 : 0;
    if (acc) begin
      mq.push_back({DT_SZ'(m_next), t});
      m_next = (m_next == NUM_MAX) ? 1 : m_next + 1;
    end else if (r && m_drop < 255) begin
      m_drop++;
    end
    m_edge++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ack"}, 32'(req_ack), e_ack);
    chk({tag, ".nak"}, 32'(req_nak), e_nak);
    chk({tag, ".out_valid"}, 32'(out_valid), e_ov);
    chk({tag, ".out_num"}, 32'(out_num), e_num);
    chk({tag, ".out_time"}, 32'(out_time), e_time);
    chk({tag, ".next_num"}, 32'(next_num), m_next);
    chk({tag, ".pend_cnt"}, 32'(pend_cnt), mq.size());
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), m_drop);
  endtask

  task automatic step(input logic r, input logic [DT_SZ-1:0] t, input string tag);
    req = r;
    req_time = t;
    @(posedge clk);
    model_edge(r, t);
    #1;
    req = 1'b0;
    req_time = '0;
    check_all(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".ack"}, 32'(req_ack), 0);
    chk({tag, ".nak"}, 32'(req_nak), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".out_num"}, 32'(out_num), 0);
    chk({tag, ".out_time"}, 32'(out_time), 0);
    chk({tag, ".next_num"}, 32'(next_num), 1);
    chk({tag, ".pend_cnt"}, 32'(pend_cnt), 0);
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  initial begin
    logic [DT_SZ-1:0] t;
    logic r;

    // Reset held across several edges, then a quiet period.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset_hold");
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, "idle");

    // Single request.
    step(1'b1, 4'd8, "single_req");
    for (int i = 0; i < 4; i++) step(1'b0, '0, "single_drain");

    // Burst of four on consecutive edges; the fourth finds the buffer full.
    step(1'b1, 4'd1, "burst0");
    step(1'b1, 4'd5, "burst1");
    step(1'b1, 4'd2, "burst2");
    step(1'b1, 4'd3, "burst3");
    for (int i = 0; i < 8; i++) step(1'b0, '0, "burst_drain");

    // Zero service time is refused.
    step(1'b1, 4'd0, "zero_time");
    for (int i = 0; i < 3; i++) step(1'b0, '0, "zero_idle");

    // Ticket numbers wrap past the maximum back to 1.
    for (int i = 0; i < 16; i++) begin
      t = DT_SZ'($urandom_range(1, NUM_MAX));
      step(1'b1, t, "wrap_req");
      repeat (3) step(1'b0, '0, "wrap_gap");
    end

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) step(1'b1, 4'd0, "drop_sat");
    chk("drop_saturated", 32'(drop_cnt), 255);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 7) == 0) ? '0 : DT_SZ'($urandom_range(1, NUM_MAX));
      step(r, t, "random");
    end

    // Reset mid-operation: two pending and the issue FSM holding.
    for (int i = 0; i < 8; i++) step(1'b0, '0, "pre_reset_drain");
    step(1'b1, 4'd4, "mid_a");
    step(1'b1, 4'd6, "mid_b");
    step(1'b1, 4'd7, "mid_c");
    chk("mid_pending_two", 32'(pend_cnt), 2);
    #2;
    rst_n = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    step(1'b1, 4'd9, "post_reset_req");
    step(1'b0, '0, "post_reset_issue");
    chk("post_reset_num", 32'(out_num), 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, "post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
